program_loader: RTL and testbench

// Writer side of the program-memory interface. The control path reads instruction words from

---
 rtl/program_loader.sv | 135 +++++++++++++
 tb/tb_program_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program-memory writer: receives a framed byte stream (SYNC, L, L words, checksum)
// and writes instruction words from address 0 while holding the core off.
module program_loader #(
    parameter int          N      = 8,
    parameter int          I_SIZE = 20,
    parameter int          P_SIZE = 5,
    parameter logic [N-1:0] SYNC  = 8'hA5
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [N-1:0]      rxData,
    input  logic              rxValid,
    output logic              rxReady,
    output logic              wrEn,
    output logic [P_SIZE-1:0] wrAddr,
    output logic [I_SIZE-1:0] wrData,
    output logic              coreHold,
    output logic              done,
    output logic              error
);

    localparam int          BYTES = (I_SIZE + N - 1) / N;
    localparam int          W     = BYTES * N;
    localparam int          BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned MAXL  = 2 ** P_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHECK
    } state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      shreg, sh_nxt;
    logic [BCW-1:0]    bcnt;
    logic [P_SIZE-1:0] addr;
    logic [P_SIZE:0]   remaining;
    logic [N-1:0]      sum;
    logic              fire, len_bad, last_byte, last_word;

    always_comb begin
        fire      = rxValid && rxReady;
        sh_nxt    = W'({shreg, rxData});
        len_bad   = (rxData == '0) || (32'(rxData) > MAXL);
        last_byte = (bcnt == BCW'(BYTES - 1));
        last_word = (remaining == (P_SIZE + 1)'(1));
        state_nxt = state;
        case (state)
            S_IDLE:  if (fire && rxData == SYNC) state_nxt = S_LEN;
            S_LEN:   if (fire) state_nxt = len_bad ? S_IDLE : S_DATA;
            S_DATA:  if (fire && last_byte) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word ? S_CHECK : S_DATA;
            S_CHECK: if (fire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // rxReady is registered from the next state so it is 0 while in reset
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rxReady   <= 1'b0;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            coreHold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            shreg     <= '0;
            bcnt      <= '0;
            addr      <= '0;
            remaining <= '0;
            sum       <= '0;
        end else begin
            rxReady <= (state_nxt != S_WRITE);
            wrEn    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire && rxData == SYNC) begin
                        coreHold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        sum      <= '0;
                        addr     <= '0;
                        bcnt     <= '0;
                    end
                end
                S_LEN: begin
                    if (fire) begin
                        sum <= rxData;
                        if (len_bad) error     <= 1'b1;
                        else         remaining <= (P_SIZE + 1)'(rxData);
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        sum   <= sum + rxData;
                        shreg <= sh_nxt;
                        if (last_byte) begin
                            bcnt   <= '0;
                            wrEn   <= 1'b1;
                            wrAddr <= addr;
                            wrData <= sh_nxt[I_SIZE-1:0];
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    remaining <= remaining - 1'b1;
                    // Hold addr on the final word so it never wraps inside a full-size frame
                    if (!last_word) addr <= addr + 1'b1;
                end
                S_CHECK: begin
                    if (fire) begin
                        if (rxData == sum) begin
                            done     <= 1'b1;
                            coreHold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, noise, bad length/checksum, full load, reset.
module tb_program_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        nRst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [19:0] wrData;
    logic        coreHold;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [4:0]  cap_addr[$];
    logic [19:0] cap_data[$];

    program_loader #(.N(8), .I_SIZE(20), .P_SIZE(5), .SYNC(8'hA5)) dut (
        .clk(clk), .nRst(nRst), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .coreHold(coreHold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nRst && wrEn) begin
            cap_addr.push_back(wrAddr);
            cap_data.push_back(wrData);
        end
    end

    // Presents a byte (after optional idle gap) and returns #1 after the consuming edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        @(negedge clk);
        if (gap > 0) begin
            rxValid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rxData  = b;
        rxValid = 1'b1;
        waited  = 0;
        while (!rxReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (waited >= 20) begin
            bad++;
            $display("FAIL send_timeout: rxReady stayed %b, required 1 (byte %h)", rxReady, b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input byte_q_t fr, input int maxgap);
        foreach (fr[i]) send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        rxValid = 1'b0;
    endtask

    task automatic test_reset;
        nRst    = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        #3;
        total++; if (wrEn !== 1'b0)     begin bad++; $display("FAIL rst_wrEn: got %b want 0", wrEn); end
        total++; if (rxReady !== 1'b0)  begin bad++; $display("FAIL rst_rxReady: got %b want 0", rxReady); end
        total++; if (coreHold !== 1'b0) begin bad++; $display("FAIL rst_coreHold: got %b want 0", coreHold); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (error !== 1'b0)    begin bad++; $display("FAIL rst_error: got %b want 0", error); end
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (rxReady !== 1'b1)  begin bad++; $display("FAIL rst_ready_after: got %b want 1", rxReady); end
    endtask

    task automatic test_good_frame;
        cap_addr.delete(); cap_data.delete();
        send_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'h0F}, 0);
        total++; if (cap_addr.size() != 2) begin bad++; $display("FAIL good_nwr: got %0d want 2", cap_addr.size()); end
        total++; if (cap_addr[0] !== 5'd0)      begin bad++; $display("FAIL good_a0: got %h want 0", cap_addr[0]); end
        total++; if (cap_data[0] !== 20'h12345) begin bad++; $display("FAIL good_d0: got %h want 12345", cap_data[0]); end
        total++; if (cap_addr[1] !== 5'd1)      begin bad++; $display("FAIL good_a1: got %h want 1", cap_addr[1]); end
        total++; if (cap_data[1] !== 20'hABCDE) begin bad++; $display("FAIL good_d1: got %h want abcde", cap_data[1]); end
        total++; if (done !== 1'b1)     begin bad++; $display("FAIL good_done: got %b want 1", done); end
        total++; if (coreHold !== 1'b0) begin bad++; $display("FAIL good_hold: got %b want 0", coreHold); end
        total++; if (error !== 1'b0)    begin bad++; $display("FAIL good_error: got %b want 0", error); end
    endtask

    task automatic test_noise;
        logic [7:0] noise[3];
        noise = '{8'h00, 8'hFF, 8'h5A};
        cap_addr.delete(); cap_data.delete();
        foreach (noise[i]) begin
            send_byte(noise[i], 0);
            total++; if (rxReady !== 1'b1)  begin bad++; $display("FAIL noise_ready%0d: got %b want 1", i, rxReady); end
            total++; if (coreHold !== 1'b0) begin bad++; $display("FAIL noise_hold%0d: got %b want 0", i, coreHold); end
        end
        rxValid = 1'b0;
        total++; if (cap_addr.size() != 0) begin bad++; $display("FAIL noise_nwr: got %0d want 0", cap_addr.size()); end
        // pad bits of 0x12 are dropped; checksum 01+12+34+56 = 9D
        send_frame('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h9D}, 0);
        total++; if (cap_addr.size() != 1) begin bad++; $display("FAIL noise_frame_nwr: got %0d want 1", cap_addr.size()); end
        total++; if (cap_addr[0] !== 5'd0)      begin bad++; $display("FAIL noise_a0: got %h want 0", cap_addr[0]); end
        total++; if (cap_data[0] !== 20'h23456) begin bad++; $display("FAIL noise_d0: got %h want 23456", cap_data[0]); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL noise_done: got %b want 1", done); end
    endtask

    task automatic test_bad_checksum;
        cap_addr.delete(); cap_data.delete();
        send_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'h10}, 0);
        total++; if (cap_addr.size() != 2) begin bad++; $display("FAIL badcs_nwr: got %0d want 2", cap_addr.size()); end
        total++; if (cap_data[1] !== 20'hABCDE) begin bad++; $display("FAIL badcs_d1: got %h want abcde", cap_data[1]); end
        total++; if (error !== 1'b1)    begin bad++; $display("FAIL badcs_error: got %b want 1", error); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL badcs_done: got %b want 0", done); end
        total++; if (coreHold !== 1'b1) begin bad++; $display("FAIL badcs_hold: got %b want 1", coreHold); end
    endtask

    task automatic test_bad_length;
        logic [7:0] lens[2];
        lens = '{8'h00, 8'h21};
        foreach (lens[i]) begin
            cap_addr.delete(); cap_data.delete();
            send_frame('{8'hA5, lens[i]}, 0);
            total++; if (error !== 1'b1)   begin bad++; $display("FAIL badlen_error%0d: got %b want 1", i, error); end
            total++; if (done !== 1'b0)    begin bad++; $display("FAIL badlen_done%0d: got %b want 0", i, done); end
            total++; if (rxReady !== 1'b1) begin bad++; $display("FAIL badlen_ready%0d: got %b want 1", i, rxReady); end
            repeat (3) @(negedge clk);
            total++; if (cap_addr.size() != 0) begin bad++; $display("FAIL badlen_nwr%0d: got %0d want 0", i, cap_addr.size()); end
        end
    endtask

    task automatic test_full_load;
        byte_q_t     fr;
        logic [23:0] words[32];
        logic [7:0]  cs;
        cap_addr.delete(); cap_data.delete();
        fr = '{8'hA5, 8'h20};
        cs = 8'h20;
        for (int i = 0; i < 32; i++) begin
            words[i] = 24'($urandom);
            for (int k = 2; k >= 0; k--) begin
                fr.push_back(words[i][k*8 +: 8]);
                cs = cs + words[i][k*8 +: 8];
            end
        end
        fr.push_back(cs);
        send_frame(fr, 2);
        total++; if (cap_addr.size() != 32) begin bad++; $display("FAIL full_nwr: got %0d want 32", cap_addr.size()); end
        for (int i = 0; i < 32; i++) begin
            total++; if (cap_addr[i] !== 5'(i)) begin bad++; $display("FAIL full_a%0d: got %h want %h", i, cap_addr[i], 5'(i)); end
            total++; if (cap_data[i] !== words[i][19:0]) begin bad++; $display("FAIL full_d%0d: got %h want %h", i, cap_data[i], words[i][19:0]); end
        end
        total++; if (done !== 1'b1)     begin bad++; $display("FAIL full_done: got %b want 1", done); end
        total++; if (error !== 1'b0)    begin bad++; $display("FAIL full_error: got %b want 0", error); end
        total++; if (coreHold !== 1'b0) begin bad++; $display("FAIL full_hold: got %b want 0", coreHold); end
    endtask

    task automatic test_reset_midframe;
        send_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0A}, 0);
        total++; if (coreHold !== 1'b1) begin bad++; $display("FAIL mid_hold_before: got %b want 1", coreHold); end
        #2 nRst = 1'b0;
        #1;
        total++; if (wrEn !== 1'b0)     begin bad++; $display("FAIL mid_wrEn: got %b want 0", wrEn); end
        total++; if (rxReady !== 1'b0)  begin bad++; $display("FAIL mid_rxReady: got %b want 0", rxReady); end
        total++; if (coreHold !== 1'b0) begin bad++; $display("FAIL mid_coreHold: got %b want 0", coreHold); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL mid_done: got %b want 0", done); end
        total++; if (error !== 1'b0)    begin bad++; $display("FAIL mid_error: got %b want 0", error); end
        @(negedge clk);
        nRst = 1'b1;
        cap_addr.delete(); cap_data.delete();
        send_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'h0F}, 1);
        total++; if (cap_addr.size() != 2) begin bad++; $display("FAIL mid_nwr: got %0d want 2", cap_addr.size()); end
        total++; if (cap_addr[0] !== 5'd0)      begin bad++; $display("FAIL mid_a0: got %h want 0", cap_addr[0]); end
        total++; if (cap_data[0] !== 20'h12345) begin bad++; $display("FAIL mid_d0: got %h want 12345", cap_data[0]); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_done_after: got %b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_noise();
        test_bad_checksum();
        test_bad_length();
        test_full_load();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
